hamming_serial_decoder: RTL and testbench

Parametrised serial Hamming decoder, successor to the fixed (7,4) serial decoder. It shifts in one codeword bit per enabled clock and locates frames with an explicit sync strobe. It corrects single-bit errors, flags errors it cannot correct, and presents the decoded word on a valid/ready output register. It sits between the UART bit receiver and downstream byte consumers.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_syndrome_calc.sv | 38 +++
 rtl/hamming_serial_decoder.sv | 125 ++++++++++++
 tb/tb_hamming_serial_decoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constant helpers for the serial Hamming decoder and its syndrome logic.
// Codeword layout: position k lives at bit k-1; parity at powers of two, data ascending LSB first.
package hamming_pkg;

    typedef enum logic {HUNT, RECV} state_t;

    // Smallest P with 2^P >= data_w + P + 1
    function automatic int calc_pw(input int data_w);
        int p;
        p = 1;
        for (int k = 0; k < 6; k++) begin
            if ((1 << p) < data_w + p + 1) p = p + 1;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!is_pow2(k)) begin
                if (cnt == i && pos == 0) pos = k;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational Hamming syndrome and single-bit correction; also used by the encoder self-check.
module hamming_syndrome_calc
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    localparam int P_W = calc_pw(DATA_W),
    localparam int N = DATA_W + P_W
) (
    input  logic [N-1:0]      codeword,
    output logic [P_W-1:0]    syndrome,
    output logic              in_range,
    output logic [DATA_W-1:0] data_raw,
    output logic [DATA_W-1:0] data_fixed
);

    logic [N-1:0] fixed_cw;

    // Syndrome is the XOR of the indices of every position holding a 1
    always_comb begin
        syndrome   = '0;
        in_range   = 1'b0;
        fixed_cw   = codeword;
        data_raw   = '0;
        data_fixed = '0;
        for (int k = 1; k <= N; k++) begin
            if (codeword[k-1]) syndrome = syndrome ^ P_W'(k);
        end
        in_range = (syndrome != '0) && (int'(syndrome) <= N);
        for (int k = 1; k <= N; k++) begin
            if (in_range && int'(syndrome) == k) fixed_cw[k-1] = ~codeword[k-1];
        end
        for (int i = 0; i < DATA_W; i++) begin
            data_raw[i]   = codeword[data_pos(i)-1];
            data_fixed[i] = fixed_cw[data_pos(i)-1];
        end
    end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial Hamming decoder: sync-framed bit capture, correction and a valid/ready output register.
// Define HAMMING_SECDED_EN to append an overall parity bit and detect double errors.
module hamming_serial_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    localparam int P_W = calc_pw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sync_in,
    input  logic              decode_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] decode_out,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [P_W-1:0]    err_syndrome,
    output logic              overrun
);

    localparam int N = DATA_W + P_W;
`ifdef HAMMING_SECDED_EN
    localparam int FRAME_LEN = N + 1;
`else
    localparam int FRAME_LEN = N;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_LEN-2:0]   shift_buf;
    logic [FRAME_LEN-1:0]   frame_word;
    logic                   frame_done;
    logic [P_W-1:0]         syndrome;
    logic                   in_range;
    logic [DATA_W-1:0]      data_raw;
    logic [DATA_W-1:0]      data_fixed;
    logic [DATA_W-1:0]      dec_data;
    logic                   dec_corr;
    logic                   dec_uncorr;

    // The incoming bit completes the frame without waiting for it to land in the buffer
    assign frame_word = {decode_in, shift_buf};
    assign frame_done = ena && !sync_in && (state == RECV) && (bit_cnt == CNT_W'(FRAME_LEN - 1));

    hamming_syndrome_calc #(.DATA_W(DATA_W)) u_syndrome (
        .codeword   (frame_word[N-1:0]),
        .syndrome   (syndrome),
        .in_range   (in_range),
        .data_raw   (data_raw),
        .data_fixed (data_fixed)
    );

`ifdef HAMMING_SECDED_EN
    logic overall_q;
    assign overall_q = ^frame_word;
`endif

    always_comb begin
        dec_data   = data_raw;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (syndrome == '0) begin
            dec_corr = overall_q;
        end else if (overall_q && in_range) begin
            dec_data = data_fixed;
            dec_corr = 1'b1;
        end else begin
            dec_uncorr = 1'b1;
        end
`else
        if (in_range) begin
            dec_data = data_fixed;
            dec_corr = 1'b1;
        end else if (syndrome != '0) begin
            dec_uncorr = 1'b1;
        end
`endif
    end

    // A sync always restarts the frame, even on what would have been its last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= HUNT;
            bit_cnt           <= '0;
            shift_buf         <= '0;
            valid_out         <= 1'b0;
            decode_out        <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_syndrome      <= '0;
            overrun           <= 1'b0;
        end else begin
            if (ena && (sync_in || state == RECV)) begin
                shift_buf <= frame_word[FRAME_LEN-1:1];
                if (sync_in) begin
                    state   <= RECV;
                    bit_cnt <= CNT_W'(1);
                end else if (frame_done) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (frame_done) begin
                if (!valid_out || ready_in) begin
                    valid_out         <= 1'b1;
                    decode_out        <= dec_data;
                    err_corrected     <= dec_corr;
                    err_uncorrectable <= dec_uncorr;
                    err_syndrome      <= syndrome;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Scoreboard bench for hamming_serial_decoder: directed cases plus randomized frames vs a reference model.
// Honours HAMMING_SECDED_EN the same way the design does.
module tb_hamming_serial_decoder;

    localparam int DW = 4;
    localparam int PW = (DW <= 1) ? 2 : (DW <= 4) ? 3 : (DW <= 11) ? 4 : 5;
    localparam int NB = DW + PW;
`ifdef HAMMING_SECDED_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [PW-1:0] synd;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          sync_in;
    logic          decode_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] decode_out;
    logic          err_corrected;
    logic          err_uncorrectable;
    logic [PW-1:0] err_syndrome;
    logic          overrun;

    exp_t sb_q[$];
    exp_t pend_exp;
    exp_t ex_none;
    exp_t mon_ex;
    logic pend_comp;
    logic pend_ready;
    logic m_valid;
    logic m_overrun;
    int   total;
    int   bad;
    int   mon_total;
    int   mon_bad;

    hamming_serial_decoder #(.DATA_W(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ena               (ena),
        .sync_in           (sync_in),
        .decode_in         (decode_in),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .decode_out        (decode_out),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_syndrome      (err_syndrome),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit tb_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [FL-1:0] encode(input logic [DW-1:0] d);
        int bits[FL+1];
        int di;
        logic [FL-1:0] f;
        di = 0;
        for (int p = 0; p <= FL; p++) bits[p] = 0;
        for (int p = 1; p <= NB; p++) begin
            if (!tb_pow2(p)) begin
                bits[p] = int'(d[di]);
                di++;
            end
        end
        for (int p = 1; p <= NB; p++) begin
            if (tb_pow2(p)) begin
                for (int q = 1; q <= NB; q++) begin
                    if (q != p && (q & p) != 0) bits[p] ^= bits[q];
                end
            end
        end
`ifdef HAMMING_SECDED_EN
        for (int p = 1; p <= NB; p++) bits[FL] ^= bits[p];
`endif
        f = '0;
        for (int p = 1; p <= FL; p++) f[p-1] = bits[p][0];
        return f;
    endfunction

    function automatic exp_t model_decode(input logic [FL-1:0] f);
        exp_t r;
        int bits[FL+1];
        int s;
        int q;
        int di;
        s = 0;
        q = 0;
        bits[0] = 0;
        for (int p = 1; p <= FL; p++) bits[p] = int'(f[p-1]);
        for (int p = 1; p <= NB; p++) if (bits[p] != 0) s ^= p;
        for (int p = 1; p <= FL; p++) q ^= bits[p];
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        r.synd   = PW'(s);
`ifdef HAMMING_SECDED_EN
        if (s == 0) begin
            r.corr = (q == 1);
        end else if (q == 1 && s <= NB) begin
            bits[s] ^= 1;
            r.corr = 1'b1;
        end else begin
            r.uncorr = 1'b1;
        end
`else
        if (s != 0 && s <= NB) begin
            bits[s] ^= 1;
            r.corr = 1'b1;
        end else if (s > NB) begin
            r.uncorr = 1'b1;
        end
`endif
        di = 0;
        r.data = '0;
        for (int p = 1; p <= NB; p++) begin
            if (!tb_pow2(p)) begin
                r.data[di] = bits[p][0];
                di++;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic checkMonitor(input string name, input logic [31:0] act, input logic [31:0] req);
        mon_total++;
        if (act !== req) begin
            mon_bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: settle the model for the edge just taken, then drive the next cycle's inputs
    task automatic step(input logic e, input logic s, input logic d, input logic r,
                        input logic comp, input exp_t ex);
        @(posedge clk);
        if (pend_comp) begin
            if (!m_valid || pend_ready) begin
                sb_q.push_back(pend_exp);
                m_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && pend_ready) begin
            m_valid = 1'b0;
        end
        #1;
        ena        = e;
        sync_in    = s;
        decode_in  = d;
        ready_in   = r;
        pend_comp  = comp;
        pend_ready = r;
        pend_exp   = ex;
    endtask

    function automatic logic rnd_ready(input int unsigned pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic applyStimulus(input logic [FL-1:0] f, input int unsigned gap_max,
                                 input int unsigned rdy_pct);
        exp_t ex;
        int unsigned g;
        ex = model_decode(f);
        for (int k = 0; k < FL; k++) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                            rnd_ready(rdy_pct), 1'b0, ex_none);
            step(1'b1, k == 0, f[k], rnd_ready(rdy_pct), k == FL - 1, ex);
        end
    endtask

    task automatic send_partial(input int len);
        for (int k = 0; k < len; k++)
            step(1'b1, k == 0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, ex_none);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        ena        = 1'b0;
        sync_in    = 1'b0;
        decode_in  = 1'b0;
        ready_in   = 1'b0;
        pend_comp  = 1'b0;
        pend_ready = 1'b0;
        m_valid    = 1'b0;
        m_overrun  = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_data", 32'(decode_out), 32'd0);
        checkOutput("rst_corr", 32'(err_corrected), 32'd0);
        checkOutput("rst_uncorr", 32'(err_uncorrectable), 32'd0);
        checkOutput("rst_synd", 32'(err_syndrome), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] d, input logic c,
                              input logic u, input logic [PW-1:0] s);
        checkOutput({name, "_valid"}, 32'(valid_out), 32'd1);
        checkOutput({name, "_data"}, 32'(decode_out), 32'(d));
        checkOutput({name, "_corr"}, 32'(err_corrected), 32'(c));
        checkOutput({name, "_uncorr"}, 32'(err_uncorrectable), 32'(u));
        checkOutput({name, "_synd"}, 32'(err_syndrome), 32'(s));
    endtask

    task automatic drain_one();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex_none);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
    endtask

    // Monitor: pops the scoreboard on every accepted word and tracks the handshake state
    always @(negedge clk) begin
        if (rst_n) begin
            checkMonitor("mon_valid", 32'(valid_out), 32'(m_valid));
            checkMonitor("mon_overrun", 32'(overrun), 32'(m_overrun));
            if (valid_out && ready_in) begin
                if (sb_q.size() == 0) begin
                    checkMonitor("mon_unexpected_word", 32'd1, 32'd0);
                end else begin
                    mon_ex = sb_q.pop_front();
                    checkMonitor("mon_data", 32'(decode_out), 32'(mon_ex.data));
                    checkMonitor("mon_corr", 32'(err_corrected), 32'(mon_ex.corr));
                    checkMonitor("mon_uncorr", 32'(err_uncorrectable), 32'(mon_ex.uncorr));
                    checkMonitor("mon_synd", 32'(err_syndrome), 32'(mon_ex.synd));
                end
            end
        end
    end

    initial begin
        logic [FL-1:0] f;
        logic [DW-1:0] d;
        logic [DW-1:0] d2;
        int p1;
        int p2;
        int nflip;
        total      = 0;
        bad        = 0;
        mon_total  = 0;
        mon_bad    = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        sync_in    = 1'b0;
        decode_in  = 1'b0;
        ready_in   = 1'b0;
        pend_comp  = 1'b0;
        pend_ready = 1'b0;
        m_valid    = 1'b0;
        m_overrun  = 1'b0;
        ex_none    = '{data: '0, corr: 1'b0, uncorr: 1'b0, synd: '0};
        pend_exp   = ex_none;
        repeat (2) @(posedge clk);
        do_reset();

        // Clean word 1,0,1,0,1,0,1 and its one-cycle latency
        f = '0;
        f[6:0] = 7'b1010101;
        applyStimulus(f, 0, 0);
        @(negedge clk);
        checkOutput("t1_valid_before", 32'(valid_out), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        check_word("t1", 4'b1011, 1'b0, 1'b0, 3'd0);
        drain_one();
        @(negedge clk);
        checkOutput("t1_valid_after", 32'(valid_out), 32'd0);

        // Position 5 flipped
        f[6:0] = 7'b1000101;
        applyStimulus(f, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        check_word("t2", 4'b1011, 1'b1, 1'b0, 3'd5);
        drain_one();

        // Positions 3 and 6 flipped, overall parity bit (if any) left at 0
        f[6:0] = 7'b1110001;
        applyStimulus(f, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
`ifdef HAMMING_SECDED_EN
        check_word("t3", 4'b1110, 1'b0, 1'b1, 3'd5);
`else
        check_word("t3", 4'b1100, 1'b1, 1'b0, 3'd5);
`endif
        drain_one();

        // Back-to-back frames with no ready: second is dropped, overrun sticks
        d  = DW'($urandom);
        d2 = DW'($urandom);
        applyStimulus(encode(d), 0, 0);
        applyStimulus(encode(d2), 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        check_word("t4", d, 1'b0, 1'b0, '0);
        checkOutput("t4_overrun", 32'(overrun), 32'd1);
        drain_one();
        @(negedge clk);
        checkOutput("t4_valid_after", 32'(valid_out), 32'd0);
        checkOutput("t4_overrun_after", 32'(overrun), 32'd1);
        do_reset();

        // Sync at bit 4 restarts the frame
        d = DW'($urandom);
        send_partial(3);
        applyStimulus(encode(d), 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        check_word("t5", d, 1'b0, 1'b0, '0);
        drain_one();

        // Reset mid-frame, unsynced bits are ignored, reset with a word pending
        send_partial(3);
        do_reset();
        f = encode(DW'($urandom));
        for (int k = 0; k < FL; k++) step(1'b1, 1'b0, f[k], 1'b0, 1'b0, ex_none);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        checkOutput("t6_hunt_valid", 32'(valid_out), 32'd0);
        d = DW'($urandom);
        applyStimulus(encode(d), 1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        check_word("t6", d, 1'b0, 1'b0, '0);
        do_reset();

        // Randomized frames with 0..2 bit errors, gaps, aborts and random backpressure
        for (int it = 0; it < 120; it++) begin
            f = encode(DW'($urandom));
            nflip = $urandom_range(2, 0);
            p1 = $urandom_range(FL - 1, 0);
            p2 = $urandom_range(FL - 1, 0);
            while (p2 == p1) p2 = $urandom_range(FL - 1, 0);
            if (nflip >= 1) f[p1] = ~f[p1];
            if (nflip >= 2) f[p2] = ~f[p2];
            if ($urandom_range(9, 0) == 0) send_partial($urandom_range(FL - 1, 1));
            applyStimulus(f, 2, 70);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex_none);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex_none);
        @(negedge clk);
        checkOutput("drain_scoreboard", 32'(sb_q.size()), 32'd0);
        checkOutput("drain_valid", 32'(valid_out), 32'd0);

        @(posedge clk);
        total = total + mon_total;
        bad   = bad + mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
